instr_encoder: RTL
==================

# instr_encoder

Encodes symbolic instruction requests (mnemonic + register/immediate fields) into 32-bit MIPS machine words using exactly the opcode/funct assignments our control decoder recognises, and buffers them in a small FIFO tagged with sequential instruction addresses. It sits upstream of instruction memory: self-test sequencers and bench drivers push requests, and the IM loader pops encoded words and addresses.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- PC_BASE, 32'h0000_3000, address tag of the first word after reset/clear
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush: empties FIFO, address counter to PC_BASE; err untouched
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- mnem  in  5  0 addu,1 subu,2 ori,3 lw,4 sw,5 beq,6 lui,7 j,8 jal,9 jr,10 jalr,11 lb,12 blez,13 rotrv,14 bltzal,15 rotr,16 clz; 17–31 illegal
- rs, rt, rd, shamt  in  5 each  register/shift fields
- imm16  in  16  immediate/offset
- target  in  26  jump target field
- out_valid  out  1  head entry valid
- out_ready  in  1  pop when out_valid && out_ready
- out_instr  out  32  encoded word at head
- out_addr  out  32  address tag of head word
- err  out  1  sticky: an illegal mnemonic was accepted
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Encoding (op[31:26] rs[25:21] rt[20:16] rd[15:11] sa[10:6] fn[5:0]); fields not listed are 0:
  - addu/subu: op 0, rs, rt, rd, fn 100001/100011
  - rotrv: op 0, rs, rt, rd, sa 00001, fn 000110
  - rotr: op 0, rs field 00001, rt, rd, sa=shamt, fn 000010
  - jr: op 0, rs, fn 001000; jalr: op 0, rs, rd, fn 001001
  - clz: op 011100, rs, rt field = rd, rd, fn 100000
  - ori 001101, lw 100011, sw 101011, lb 100000, beq 000100: op, rs, rt, imm16
  - lui 001111: rt, imm16 (rs 0); blez 000110: rs, imm16 (rt 0)
  - bltzal: op 000001, rs, rt field 10000, imm16
  - j 000010 / jal 000011: op, target
- Unused input fields are ignored, never leak into the word.
- Legal accepted request: encoded word + current address counter written at tail; counter += 4 (mod 2^32).
- Illegal accepted request: nothing written, counter unchanged, err set to 1 (cleared only by reset).
- Pop: head advances, count decrements; pointers wrap mod DEPTH.
- Push and pop in same cycle: both occur, count unchanged.
- Priority: reset > clear > push/pop. clear in same cycle as handshakes discards both; the popped word is not considered delivered.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr 0, count 0, err 0, counter PC_BASE, in_ready 0 while reset high.
- in_ready = !reset && (count < DEPTH) — depends on registered count only, no combinational path from out_ready.
- out_valid = (count != 0); out_instr/out_addr driven 0 when empty.
- Latency: request accepted at edge N → out_valid/out_instr/out_addr valid after edge N (readable in cycle N+1).
- Full: in_ready low; a pop at the same edge does not admit a push that cycle; in_ready returns the cycle after the pop.
- Empty: no pop; push appears next cycle.
- Reset/clear mid-stream: all queued words lost; next accepted word tagged PC_BASE.

## Test plan
- Encode set, out_ready=1: addu rd=3 rs=1 rt=2 → 0x00221821 @0x3000; ori rt=1 rs=0 imm=0x1234 → 0x34011234 @0x3004; lui rt=8 imm=0xFFFF → 0x3C08FFFF @0x3008; j target=0xC03 → 0x08000C03 @0x300C.
- Special fields: bltzal rs=4 imm=0xFFFE → 0x0490FFFE; rotr rd=5 rt=6 shamt=3 → 0x002628C2; clz rd=7 rs=9 rt=31 → 0x71273820 (rt input ignored).
- Backpressure: out_ready=0, push 5 back-to-back → 4 accepted, count=4, in_ready=0; then out_ready=1 → words drained in order with addrs 0x3000..0x300C, 5th request accepted one cycle after first pop, tagged 0x3010.
- Illegal: mnem=20 handshake → err=1, count unchanged, next legal word tagged address that was current before it; err persists through clear.
- Simultaneous push/pop at count=2 → count stays 2, order preserved.
- Reset/clear mid-operation: 3 queued, pulse clear 1 cycle → out_valid=0, count=0; next addu tagged 0x3000; same with reset also clears err.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit words and queues them
// with sequential address tags for the instruction-memory loader.
module instr_encoder #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               mnem,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [15:0]              imm16,
  input  logic [25:0]              target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [4:0] MN_ADDU   = 5'd0;
  localparam logic [4:0] MN_SUBU   = 5'd1;
  localparam logic [4:0] MN_ORI    = 5'd2;
  localparam logic [4:0] MN_LW     = 5'd3;
  localparam logic [4:0] MN_SW     = 5'd4;
  localparam logic [4:0] MN_BEQ    = 5'd5;
  localparam logic [4:0] MN_LUI    = 5'd6;
  localparam logic [4:0] MN_J      = 5'd7;
  localparam logic [4:0] MN_JAL    = 5'd8;
  localparam logic [4:0] MN_JR     = 5'd9;
  localparam logic [4:0] MN_JALR   = 5'd10;
  localparam logic [4:0] MN_LB     = 5'd11;
  localparam logic [4:0] MN_BLEZ   = 5'd12;
  localparam logic [4:0] MN_ROTRV  = 5'd13;
  localparam logic [4:0] MN_BLTZAL = 5'd14;
  localparam logic [4:0] MN_ROTR   = 5'd15;
  localparam logic [4:0] MN_CLZ    = 5'd16;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [31:0]      addr_mem_q  [DEPTH];
  logic [31:0]      addr_mem_d  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic             err_q, err_d;

  logic [31:0]      enc_word;
  logic             enc_legal;
  logic             push, pop;

  // Mnemonic to machine word; only the fields each format uses are placed.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (mnem)
      MN_ADDU:   enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
      MN_SUBU:   enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
      MN_ROTRV:  enc_word = {6'b000000, rs, rt, rd, 5'd1, 6'b000110};
      MN_ROTR:   enc_word = {6'b000000, 5'd1, rt, rd, shamt, 6'b000010};
      MN_JR:     enc_word = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      MN_JALR:   enc_word = {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};
      MN_CLZ:    enc_word = {6'b011100, rs, rd, rd, 5'd0, 6'b100000};
      MN_ORI:    enc_word = {6'b001101, rs, rt, imm16};
      MN_LW:     enc_word = {6'b100011, rs, rt, imm16};
      MN_SW:     enc_word = {6'b101011, rs, rt, imm16};
      MN_LB:     enc_word = {6'b100000, rs, rt, imm16};
      MN_BEQ:    enc_word = {6'b000100, rs, rt, imm16};
      MN_LUI:    enc_word = {6'b001111, 5'd0, rt, imm16};
      MN_BLEZ:   enc_word = {6'b000110, rs, 5'd0, imm16};
      MN_BLTZAL: enc_word = {6'b000001, rs, 5'b10000, imm16};
      MN_J:      enc_word = {6'b000010, target};
      MN_JAL:    enc_word = {6'b000011, target};
      default:   enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = !reset && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem_q[head_q] : 32'd0;
  assign out_addr  = out_valid ? addr_mem_q[head_q]  : 32'd0;
  assign err       = err_q;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Queue bookkeeping; clear discards any handshake in the same cycle.
  always_comb begin
    instr_mem_d = instr_mem_q;
    addr_mem_d  = addr_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_d        = pc_q;
    err_d       = err_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = PC_BASE;
    end else begin
      if (pop) begin
        head_d  = head_q + PTR_W'(1);
        count_d = count_d - CNT_W'(1);
      end
      if (push && enc_legal) begin
        instr_mem_d[tail_q] = enc_word;
        addr_mem_d[tail_q]  = pc_q;
        tail_d              = tail_q + PTR_W'(1);
        count_d             = count_d + CNT_W'(1);
        pc_d                = pc_q + 32'd4;
      end else if (push) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        addr_mem_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= PC_BASE;
      err_q   <= 1'b0;
    end else begin
      instr_mem_q <= instr_mem_d;
      addr_mem_q  <= addr_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      err_q       <= err_d;
    end
  end

endmodule
